wb_burst_reader: RTL and testbench
==================================

// Module: wb_burst_reader
// PURPOSE
//  Wishbone master that reads a block of 32-bit words from a Wishbone slave (e.g. the BRAM
//  controller) with incrementing-address bursts, and streams the words out via valid/ready.
//  Sits between a memory slave and a consumer (video/pixel pipeline, checksum, UART dump).
//  Flow control: a burst is issued only when the internal FIFO can absorb the whole burst.
// PARAMETERS
//  BURST_LEN  8   max beats per Wishbone burst (power of 2, >=1)
//  FIFO_DEPTH 16  output FIFO depth in words (power of 2, >= BURST_LEN)
//  CNT_W      16  width of the word-count input
// PORTS
//  clk        in   1      system clock; the clock of the wshb_if instance is this same clock
//  reset_n    in   1      asynchronous reset, active low
//  start      in   1      1-cycle request; sampled only in IDLE
//  base_adr   in   32     byte address of first word; bits [1:0] ignored (forced 0)
//  nwords     in   CNT_W  number of words to read; 0 allowed
//  busy       out  1      high from the cycle after an accepted start until done/err
//  done       out  1      1-cycle pulse: all nwords words written into the FIFO
//  err        out  1      1-cycle pulse: slave answered err; transfer aborted
//  wb_m       --   if     wshb_if.master: cyc,stb,we,sel,adr,cti,bte out; dat_sm,ack,err,rty in
//  out_data   out  32     FIFO head word
//  out_valid  out  1      FIFO not empty
//  out_ready  in   1      consumer pops head when out_valid & out_ready
// BEHAVIOUR
//  Reset: cyc=stb=we=0, sel=4'hF, adr=0, cti=3'b000, bte=2'b00, busy=done=err=0, FIFO empty.
//  Reset mid-burst: all state is cleared immediately (asynchronous); cyc drops; no done/err.
//  Constant outputs: we=0, sel=4'hF, bte=2'b00 (linear).
//  FSM states: IDLE, WAIT_SPACE, BURST, FINISH.
//   IDLE: start & nwords!=0 -> WAIT_SPACE; latch adr=base_adr&~3 and remaining=nwords.
//         start & nwords==0 -> FINISH (no bus cycle; done pulses 2 cycles after start).
//   WAIT_SPACE: beats = min(remaining, BURST_LEN). Go to BURST when free slots >= beats.
//         free slots = FIFO_DEPTH - FIFO count.
//         cyc/stb assert in the first BURST cycle (>=1 cycle after start).
//   BURST: cyc=stb=1. cti=3'b010 on every beat except the last, which uses 3'b111.
//         A 1-beat burst uses cti=3'b000 (classic).
//         Each cycle with ack: push dat_sm into FIFO, adr+=4 (mod 2^32), remaining-=1.
//         When the last beat of the burst is acked, the same edge drops cyc/stb, then:
//         remaining==0 -> FINISH, else -> WAIT_SPACE.
//         cyc is low >= 1 cycle between bursts.
//         rty: treated as no ack; stb stays high on the same address (retry).
//         err: no push; cyc/stb drop on that edge; err pulses next cycle; -> IDLE.
//         The FIFO keeps its contents on err.
//         ack and err in the same cycle: err wins.
//   FINISH: done=1 for one cycle -> IDLE. busy=0 in IDLE.
//  Stall safety: BURST never starts without room, so a push never hits a full FIFO.
//   Pop during push: both take effect; count unchanged.
//  FIFO output: first-word-fall-through. out_data is valid in the same cycle out_valid rises.
//   Data order equals address order.
//  start while busy: ignored.
//  FIFO contents remain poppable after done or err.
// STRUCTURE
//  Package wb_master_pkg:
//   cti_t enum {CTI_CLASSIC=3'b000, CTI_CONST=3'b001, CTI_INCR=3'b010, CTI_END=3'b111}
//   bte_t enum {BTE_LINEAR=2'b00}
//   state_t enum {IDLE, WAIT_SPACE, BURST, FINISH}
//  Sub-module wb_rd_fifo #(DEPTH, W=32):
//   sync FWFT FIFO with push, pop, data in/out, count, empty, full; async active-low reset.
//  Top: FSM, address/remaining/beat counters, burst-length min() logic.
// TESTING
//  1. base_adr=0x100, nwords=20, BURST_LEN=8, out_ready=1.
//     -> bursts of 8,8,4 at adr 0x100,0x120,0x140; cti 010..010,111 per burst.
//     -> 20 words out in address order; done pulse once.
//  2. out_ready=0, nwords=40, FIFO_DEPTH=16.
//     -> exactly 2 bursts (16 words), then cyc stays 0 in WAIT_SPACE.
//     -> raise out_ready: remaining 24 words follow; no overflow.
//  3. nwords=1 -> single beat, cti=000, stb held until ack; done 1 cycle after FINISH entry.
//     nwords=0 -> no cyc; done 2 cycles after start.
//  4. Slave asserts rty twice on beat 3, then ack -> same adr repeated; data sequence intact.
//     Slave asserts err on beat 5 -> cyc drops; err pulse; 4 words left in FIFO; busy=0.
//  5. base_adr=0xFFFF_FFF8, nwords=4 -> adr 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 (wrap).
//  6. reset_n low mid-burst -> cyc=0, FIFO empty, busy=0 with no clock edge.
//     A new start after release runs normally.

Source files
------------

// File: rtl/wb_master_pkg.sv
// Shared types for the Wishbone burst-read master: cycle-type tags, burst
// type and the controller state encoding.
package wb_master_pkg;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_CONST   = 3'b001,
    CTI_INCR    = 3'b010,
    CTI_END     = 3'b111
  } cti_t;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00
  } bte_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SPACE,
    BURST,
    FINISH
  } state_t;

  localparam logic [3:0]  SEL_ALL    = 4'hF;
  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/wshb_if.sv
// Read-side Wishbone B4 bundle between a burst master and a 32-bit slave.
interface wshb_if;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_sm;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    output cyc, stb, we, sel, adr, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, sel, adr, cti, bte,
    output dat_sm, ack, err, rty
  );

endinterface

// File: rtl/wb_rd_fifo.sv
// First-word-fall-through FIFO: the head word is on dout whenever empty is low.
// DEPTH must be a power of two and at least 2.
module wb_rd_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by count, so
  // stale words are never observable and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/wb_burst_reader.sv
// Wishbone master that reads nwords words in incrementing bursts, issuing a
// burst only when the output FIFO can absorb all of it, and streams them out.
module wb_burst_reader
  import wb_master_pkg::*;
#(
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      base_adr,
  input  logic [CNT_W-1:0] nwords,
  output logic             busy,
  output logic             done,
  output logic             err,
  wshb_if.master           wb_m,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int BEAT_W = $clog2(BURST_LEN) + 1;
  localparam int CNT_FW = $clog2(FIFO_DEPTH) + 1;

  state_t             state_q;
  state_t             state_d;
  logic [31:0]        adr_q;
  logic [CNT_W-1:0]   remaining_q;
  logic [BEAT_W-1:0]  beats_left_q;
  logic               single_q;
  logic               done_q;
  logic               err_q;

  logic [CNT_FW-1:0]  fifo_count;
  logic               fifo_empty;
  logic               fifo_full;
  logic [BEAT_W-1:0]  burst_beats;
  logic               room_ok;
  logic               beat_ack;
  logic               bus_err;
  logic               last_beat;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    burst_beats = (remaining_q >= CNT_W'(BURST_LEN)) ? BEAT_W'(BURST_LEN)
                                                     : remaining_q[BEAT_W-1:0];
    room_ok     = (CNT_FW'(FIFO_DEPTH) - fifo_count) >= CNT_FW'(burst_beats);
    bus_err     = (state_q == BURST) & wb_m.err;
    // rty and err both override ack; a retried beat repeats the same address.
    beat_ack    = (state_q == BURST) & wb_m.ack & ~wb_m.err & ~wb_m.rty;
    last_beat   = (beats_left_q == BEAT_W'(1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (start) state_d = (nwords == '0) ? FINISH : WAIT_SPACE;
      WAIT_SPACE: if (room_ok) state_d = BURST;
      BURST: begin
        if (bus_err)
          state_d = IDLE;
        else if (beat_ack && last_beat)
          state_d = (remaining_q == CNT_W'(1)) ? FINISH : WAIT_SPACE;
      end
      FINISH:     state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adr_q        <= '0;
      remaining_q  <= '0;
      beats_left_q <= '0;
      single_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          adr_q       <= base_adr & ~32'd3;
          remaining_q <= nwords;
        end
        WAIT_SPACE: if (room_ok) begin
          beats_left_q <= burst_beats;
          single_q     <= (burst_beats == BEAT_W'(1));
        end
        BURST: if (beat_ack) begin
          adr_q        <= adr_q + WORD_BYTES;
          remaining_q  <= remaining_q - CNT_W'(1);
          beats_left_q <= beats_left_q - BEAT_W'(1);
        end
        default: ;
      endcase
      done_q <= (state_q == FINISH);
      err_q  <= bus_err;
    end
  end

  always_comb begin
    wb_m.cyc = 1'b0;
    wb_m.stb = 1'b0;
    wb_m.cti = CTI_CLASSIC;
    if (state_q == BURST) begin
      wb_m.cyc = 1'b1;
      wb_m.stb = 1'b1;
      if (!single_q) wb_m.cti = last_beat ? CTI_END : CTI_INCR;
    end
  end

  assign wb_m.we  = 1'b0;
  assign wb_m.sel = SEL_ALL;
  assign wb_m.bte = BTE_LINEAR;
  assign wb_m.adr = adr_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign err      = err_q;

  wb_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .push  (beat_ack),
    .din   (wb_m.dat_sm),
    .pop   (out_valid & out_ready),
    .dout  (out_data),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign out_valid = ~fifo_empty;

  // A burst only starts with room for all its beats, so pushes never meet a full FIFO.
  assert property (@(posedge clk) disable iff (!reset_n) !(beat_ack && fifo_full));

endmodule

// File: tb/tb_wb_burst_reader.sv
// Directed bench for wb_burst_reader: a scripted Wishbone slave returns ~adr as
// read data and can stall, retry or error on a chosen beat.
module tb_wb_burst_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_adr = '0;
  logic [15:0] nwords = '0;
  logic        busy, done, err;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  wshb_if wb ();

  wb_burst_reader #(
    .BURST_LEN  (8),
    .FIFO_DEPTH (16),
    .CNT_W      (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_adr  (base_adr),
    .nwords    (nwords),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .wb_m      (wb),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Slave script, written by the tests.
  int test_id = 0;
  int err_at = -1, rty_at = -1, rty_n = 0, wait_at = -1, wait_n = 0;

  // Slave state and observation log, owned by the slave process.
  int last_id = 0, beat_idx = 0, rty_cnt = 0, wait_cnt = 0, cyc_num = 0;
  int bursts = 0, done_n = 0, err_n = 0, done_cyc = 0, start_cyc = 0, ack_cyc = 0;
  logic cyc_prev = 1'b0, busy_at_err = 1'b1, cyc_at_err = 1'b1;
  logic [31:0] ack_adr[$], stb_adr[$], rx[$];
  logic [2:0]  ack_cti[$];

  // Responses are decided at the falling edge and held across the rising edge.
  always @(negedge clk) begin
    cyc_num++;
    if (test_id != last_id) begin
      last_id = test_id; beat_idx = 0; rty_cnt = 0; wait_cnt = 0;
      bursts = 0; done_n = 0; err_n = 0;
      ack_adr.delete(); stb_adr.delete(); rx.delete(); ack_cti.delete();
    end
    wb.ack = 1'b0; wb.err = 1'b0; wb.rty = 1'b0;
    wb.dat_sm = ~wb.adr;
    if (wb.cyc && wb.stb) begin
      stb_adr.push_back(wb.adr);
      if (!cyc_prev) bursts++;
      if (beat_idx == err_at) wb.err = 1'b1;
      else if (beat_idx == rty_at && rty_cnt < rty_n) begin wb.rty = 1'b1; rty_cnt++; end
      else if (beat_idx == wait_at && wait_cnt < wait_n) wait_cnt++;
      else begin
        wb.ack = 1'b1;
        ack_adr.push_back(wb.adr); ack_cti.push_back(wb.cti);
        ack_cyc = cyc_num; beat_idx++;
      end
    end
    cyc_prev = wb.cyc;
    if (out_valid && out_ready) rx.push_back(out_data);
    if (start) start_cyc = cyc_num;
    if (done) begin done_n++; done_cyc = cyc_num; end
    if (err) begin err_n++; busy_at_err = busy; cyc_at_err = wb.cyc; end
  end

  task automatic new_test();
    @(posedge clk); #1;
    test_id++;
    err_at = -1; rty_at = -1; rty_n = 0; wait_at = -1; wait_n = 0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input logic [31:0] a, input int n);
    @(posedge clk); #1;
    base_adr = a; nwords = 16'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, input string name);
    int k = 0;
    while (done_n + err_n == 0 && k < budget) begin @(negedge clk); k++; end
    n_cmp++;
    if (done_n + err_n == 0) begin
      $display("FAIL %s_timeout: no done/err within %0d cycles", name, budget);
      n_bad++;
    end
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k = 0;
    while (rx.size() < n && k < budget) begin @(negedge clk); k++; end
  endtask

  task automatic test_reset();
    logic [45:0] got_bus, exp_bus;
    logic [3:0]  got_st;
    #1;
    got_bus = {wb.cyc, wb.stb, wb.we, wb.sel, wb.adr, wb.cti, wb.bte};
    exp_bus = {1'b0, 1'b0, 1'b0, 4'hF, 32'h0, 3'b000, 2'b00};
    n_cmp++;
    if (got_bus !== exp_bus) begin
      $display("FAIL reset_bus: got %h want %h", got_bus, exp_bus); n_bad++;
    end
    got_st = {busy, done, err, out_valid};
    n_cmp++;
    if (got_st !== 4'b0000) begin
      $display("FAIL reset_status: busy/done/err/valid got %b want 0000", got_st); n_bad++;
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_burst_split();
    logic [34:0] got, exp;
    new_test();
    out_ready = 1'b1;
    pulse_start(32'h100, 20);
    wait_end(200, "split");
    wait_rx(20, 50);
    n_cmp++;
    if (done_n !== 1 || err_n !== 0 || bursts !== 3 || busy !== 1'b0) begin
      $display("FAIL split_counts: done %0d err %0d bursts %0d busy %b want 1 0 3 0",
               done_n, err_n, bursts, busy); n_bad++;
    end
    for (int i = 0; i < 20; i++) begin
      exp = {32'h100 + 32'(4 * i), (i % 8 == 7 || i == 19) ? 3'b111 : 3'b010};
      got = (i < ack_adr.size()) ? {ack_adr[i], ack_cti[i]} : '1;
      n_cmp++;
      if (got !== exp) begin
        $display("FAIL split_beat%0d: adr/cti got %h want %h", i, got, exp); n_bad++;
      end
      n_cmp++;
      if (i >= rx.size() || rx[i] !== ~(32'h100 + 32'(4 * i))) begin
        $display("FAIL split_data%0d: got %h want %h", i,
                 (i < rx.size()) ? rx[i] : 32'hx, ~(32'h100 + 32'(4 * i))); n_bad++;
      end
    end
  endtask

  task automatic test_backpressure();
    new_test();
    out_ready = 1'b0;
    pulse_start(32'h200, 40);
    repeat (30) @(negedge clk);
    pulse_start(32'h900, 3);   // busy: must be ignored
    repeat (30) @(negedge clk);
    n_cmp++;
    if (bursts !== 2 || ack_adr.size() !== 16 || wb.cyc !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) begin
      $display("FAIL bp_stall: bursts %0d acks %0d cyc %b busy %b valid %b want 2 16 0 1 1",
               bursts, ack_adr.size(), wb.cyc, busy, out_valid); n_bad++;
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_end(400, "bp");
    wait_rx(40, 100);
    n_cmp++;
    if (bursts !== 5 || done_n !== 1 || rx.size() !== 40 || ack_adr.size() !== 40) begin
      $display("FAIL bp_totals: bursts %0d done %0d rx %0d acks %0d want 5 1 40 40",
               bursts, done_n, rx.size(), ack_adr.size()); n_bad++;
    end
    for (int i = 0; i < 40; i++) begin
      n_cmp++;
      if (i >= rx.size() || rx[i] !== ~(32'h200 + 32'(4 * i))) begin
        $display("FAIL bp_data%0d: got %h want %h", i,
                 (i < rx.size()) ? rx[i] : 32'hx, ~(32'h200 + 32'(4 * i))); n_bad++;
      end
    end
  endtask

  task automatic test_single_and_zero();
    new_test();
    out_ready = 1'b1;
    wait_at = 0; wait_n = 3;
    pulse_start(32'h40, 1);
    wait_end(50, "single");
    wait_rx(1, 10);
    n_cmp++;
    if (stb_adr.size() !== 4 || stb_adr[0] !== 32'h40 || stb_adr[3] !== 32'h40) begin
      $display("FAIL single_hold: stb cycles %0d want 4 at adr 40", stb_adr.size()); n_bad++;
    end
    n_cmp++;
    if (ack_cti.size() !== 1 || ack_cti[0] !== 3'b000) begin
      $display("FAIL single_cti: acks %0d cti %b want 1 000", ack_cti.size(),
               (ack_cti.size() > 0) ? ack_cti[0] : 3'bx); n_bad++;
    end
    n_cmp++;
    if (done_cyc - ack_cyc !== 2 || rx.size() !== 1 || rx[0] !== ~32'h40) begin
      $display("FAIL single_done: done-ack %0d rx %0d want 2 1", done_cyc - ack_cyc, rx.size()); n_bad++;
    end

    new_test();
    pulse_start(32'h80, 0);
    wait_end(20, "zero");
    n_cmp++;
    if (done_cyc - start_cyc !== 2 || stb_adr.size() !== 0 || done_n !== 1) begin
      $display("FAIL zero_words: done-start %0d stb cycles %0d done %0d want 2 0 1",
               done_cyc - start_cyc, stb_adr.size(), done_n); n_bad++;
    end
  endtask

  task automatic test_retry();
    logic [31:0] exp_stb [10];
    exp_stb = '{32'h300, 32'h304, 32'h308, 32'h308, 32'h308,
                32'h30C, 32'h310, 32'h314, 32'h318, 32'h31C};
    new_test();
    out_ready = 1'b1;
    rty_at = 2; rty_n = 2;
    pulse_start(32'h302, 8);
    wait_end(60, "retry");
    wait_rx(8, 20);
    n_cmp++;
    if (stb_adr.size() !== 10) begin
      $display("FAIL retry_len: stb cycles %0d want 10", stb_adr.size()); n_bad++;
    end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (i >= stb_adr.size() || stb_adr[i] !== exp_stb[i]) begin
        $display("FAIL retry_adr%0d: got %h want %h", i,
                 (i < stb_adr.size()) ? stb_adr[i] : 32'hx, exp_stb[i]); n_bad++;
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (i >= rx.size() || rx[i] !== ~(32'h300 + 32'(4 * i))) begin
        $display("FAIL retry_data%0d: got %h want %h", i,
                 (i < rx.size()) ? rx[i] : 32'hx, ~(32'h300 + 32'(4 * i))); n_bad++;
      end
    end
  endtask

  task automatic test_error();
    new_test();
    out_ready = 1'b0;
    err_at = 4;
    pulse_start(32'h400, 8);
    wait_end(60, "error");
    n_cmp++;
    if (err_n !== 1 || done_n !== 0 || busy_at_err !== 1'b0 || cyc_at_err !== 1'b0) begin
      $display("FAIL err_pulse: err %0d done %0d busy %b cyc %b want 1 0 0 0",
               err_n, done_n, busy_at_err, cyc_at_err); n_bad++;
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ack_adr.size() !== 4 || out_valid !== 1'b1 || busy !== 1'b0 || wb.cyc !== 1'b0) begin
      $display("FAIL err_after: acks %0d valid %b busy %b cyc %b want 4 1 0 0",
               ack_adr.size(), out_valid, busy, wb.cyc); n_bad++;
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_rx(4, 20);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rx.size() !== 4 || out_valid !== 1'b0) begin
      $display("FAIL err_fifo: kept words %0d valid %b want 4 0", rx.size(), out_valid); n_bad++;
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= rx.size() || rx[i] !== ~(32'h400 + 32'(4 * i))) begin
        $display("FAIL err_data%0d: got %h want %h", i,
                 (i < rx.size()) ? rx[i] : 32'hx, ~(32'h400 + 32'(4 * i))); n_bad++;
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_adr [4];
    logic [2:0]  exp_cti [4];
    exp_adr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    exp_cti = '{3'b010, 3'b010, 3'b010, 3'b111};
    new_test();
    out_ready = 1'b1;
    pulse_start(32'hFFFF_FFF8, 4);
    wait_end(40, "wrap");
    wait_rx(4, 20);
    n_cmp++;
    if (bursts !== 1 || ack_adr.size() !== 4) begin
      $display("FAIL wrap_count: bursts %0d acks %0d want 1 4", bursts, ack_adr.size()); n_bad++;
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= ack_adr.size() || ack_adr[i] !== exp_adr[i] || ack_cti[i] !== exp_cti[i]
          || i >= rx.size() || rx[i] !== ~exp_adr[i]) begin
        $display("FAIL wrap_beat%0d: adr %h cti %b want %h %b", i,
                 (i < ack_adr.size()) ? ack_adr[i] : 32'hx,
                 (i < ack_cti.size()) ? ack_cti[i] : 3'bx, exp_adr[i], exp_cti[i]); n_bad++;
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int k = 0;
    new_test();
    out_ready = 1'b0;
    wait_at = 3; wait_n = 100;
    pulse_start(32'h500, 16);
    while (ack_adr.size() < 3 && k < 30) begin @(negedge clk); k++; end
    @(negedge clk);
    n_cmp++;
    if (wb.cyc !== 1'b1 || out_valid !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL mid_pre: cyc %b valid %b busy %b want 1 1 1", wb.cyc, out_valid, busy); n_bad++;
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (wb.cyc !== 1'b0 || wb.stb !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL mid_reset: cyc %b stb %b valid %b busy %b want 0 0 0 0",
               wb.cyc, wb.stb, out_valid, busy); n_bad++;
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (done_n !== 0 || err_n !== 0) begin
      $display("FAIL mid_pulses: done %0d err %0d want 0 0", done_n, err_n); n_bad++;
    end
    new_test();
    out_ready = 1'b1;
    pulse_start(32'h600, 4);
    wait_end(40, "restart");
    wait_rx(4, 20);
    n_cmp++;
    if (done_n !== 1 || rx.size() !== 4 || ack_adr.size() !== 4) begin
      $display("FAIL restart_totals: done %0d rx %0d acks %0d want 1 4 4",
               done_n, rx.size(), ack_adr.size()); n_bad++;
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= rx.size() || rx[i] !== ~(32'h600 + 32'(4 * i))) begin
        $display("FAIL restart_data%0d: got %h want %h", i,
                 (i < rx.size()) ? rx[i] : 32'hx, ~(32'h600 + 32'(4 * i))); n_bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_burst_split();
    test_backpressure();
    test_single_and_zero();
    test_retry();
    test_error();
    test_wrap();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
